// File: rtl/i2c_slave_top.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_slave_top
//  Description : I2C slave exposing a byte-addressable register memory.
//                7-bit device address, 16-bit MSB-first register pointer,
//                burst writes/reads with pointer auto-increment. The bus is
//                oversampled on the system clock; SDA is open-drain.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_slave_top #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         MEM_DEPTH  = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic SCL_bus,
  inout  wire  SDA_bus
);

  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    DEV_ADDR  = 4'd1,
    ACK_DEV   = 4'd2,
    REG_HI    = 4'd3,
    ACK_HI    = 4'd4,
    REG_LO    = 4'd5,
    ACK_LO    = 4'd6,
    WR_DATA   = 4'd7,
    ACK_WR    = 4'd8,
    RD_DATA   = 4'd9,
    RD_ACK    = 4'd10,
    WAIT_STOP = 4'd11
  } state_t;

  // Synchronizer stages: [0],[1] resynchronize, [2] holds the previous value
  logic [2:0]  scl_sync;
  logic [2:0]  sda_sync;

  state_t      state;
  logic [3:0]  bit_cnt;
  logic [7:0]  shift;
  logic [15:0] pointer;
  logic        rw;
  logic        master_ack;
  logic        sda_low;
  logic [7:0]  mem [MEM_DEPTH];

  logic          scl_in;
  logic          sda_in;
  logic          scl_rise;
  logic          scl_fall;
  logic          start_cond;
  logic          stop_cond;
  logic          byte_done;
  logic [15:0]   ptr_inc;
  logic [AW-1:0] ptr_idx;
  logic [AW-1:0] ptr_inc_idx;
  logic [7:0]    rd_byte;
  logic [7:0]    nxt_byte;

  // Open-drain pad: only ever pull low or release
  assign SDA_bus = sda_low ? 1'b0 : 1'bz;

  assign scl_in     = scl_sync[1];
  assign sda_in     = sda_sync[1];
  assign scl_rise   = scl_sync[1] & ~scl_sync[2];
  assign scl_fall   = ~scl_sync[1] & scl_sync[2];
  assign start_cond = scl_in & ~sda_sync[1] & sda_sync[2];
  assign stop_cond  = scl_in & sda_sync[1] & ~sda_sync[2];
  assign byte_done  = scl_fall && (bit_cnt == 4'd8);

  assign ptr_inc     = pointer + 16'd1;
  assign ptr_idx     = pointer[AW-1:0];
  assign ptr_inc_idx = ptr_inc[AW-1:0];
  assign rd_byte     = mem[ptr_idx];
  assign nxt_byte    = mem[ptr_inc_idx];

  // Bus input synchronizers; reset to the idle-high level to avoid false edges
  always_ff @(posedge clk) begin
    if (!rst) begin
      scl_sync <= 3'b111;
      sda_sync <= 3'b111;
    end else begin
      scl_sync <= {scl_sync[1:0], SCL_bus};
      sda_sync <= {sda_sync[1:0], SDA_bus};
    end
  end

  // Protocol FSM, pointer, memory and SDA driver (driver changes only on SCL fall)
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      bit_cnt    <= 4'd0;
      shift      <= 8'h00;
      pointer    <= 16'h0000;
      rw         <= 1'b0;
      master_ack <= 1'b0;
      sda_low    <= 1'b0;
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem[i] <= 8'h00;
      end
    end else if (start_cond) begin
      state   <= DEV_ADDR;
      bit_cnt <= 4'd0;
      shift   <= 8'h00;
      sda_low <= 1'b0;
    end else if (stop_cond) begin
      state   <= IDLE;
      bit_cnt <= 4'd0;
      sda_low <= 1'b0;
    end else begin
      case (state)
        IDLE, WAIT_STOP: begin
          sda_low <= 1'b0;
        end

        DEV_ADDR: begin
          if (scl_rise) begin
            shift   <= {shift[6:0], sda_in};
            bit_cnt <= bit_cnt + 4'd1;
          end else if (byte_done) begin
            bit_cnt <= 4'd0;
            rw      <= shift[0];
            if (shift[7:1] == SLAVE_ADDR) begin
              sda_low <= 1'b1;
              state   <= ACK_DEV;
            end else begin
              state   <= WAIT_STOP;
            end
          end
        end

        ACK_DEV: begin
          if (scl_fall) begin
            if (rw) begin
              // Read: first data bit goes out on the edge that ends the ACK
              shift   <= rd_byte;
              sda_low <= ~rd_byte[7];
              bit_cnt <= 4'd1;
              state   <= RD_DATA;
            end else begin
              sda_low <= 1'b0;
              bit_cnt <= 4'd0;
              state   <= REG_HI;
            end
          end
        end

        REG_HI: begin
          if (scl_rise) begin
            shift   <= {shift[6:0], sda_in};
            bit_cnt <= bit_cnt + 4'd1;
          end else if (byte_done) begin
            bit_cnt       <= 4'd0;
            pointer[15:8] <= shift;
            sda_low       <= 1'b1;
            state         <= ACK_HI;
          end
        end

        ACK_HI: begin
          if (scl_fall) begin
            sda_low <= 1'b0;
            state   <= REG_LO;
          end
        end

        REG_LO: begin
          if (scl_rise) begin
            shift   <= {shift[6:0], sda_in};
            bit_cnt <= bit_cnt + 4'd1;
          end else if (byte_done) begin
            bit_cnt      <= 4'd0;
            pointer[7:0] <= shift;
            sda_low      <= 1'b1;
            state        <= ACK_LO;
          end
        end

        ACK_LO: begin
          if (scl_fall) begin
            sda_low <= 1'b0;
            state   <= WR_DATA;
          end
        end

        WR_DATA: begin
          if (scl_rise) begin
            shift   <= {shift[6:0], sda_in};
            bit_cnt <= bit_cnt + 4'd1;
          end else if (byte_done) begin
            bit_cnt      <= 4'd0;
            mem[ptr_idx] <= shift;
            pointer      <= ptr_inc;
            sda_low      <= 1'b1;
            state        <= ACK_WR;
          end
        end

        ACK_WR: begin
          if (scl_fall) begin
            sda_low <= 1'b0;
            state   <= WR_DATA;
          end
        end

        RD_DATA: begin
          if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              sda_low <= 1'b0;
              state   <= RD_ACK;
            end else begin
              shift   <= {shift[6:0], 1'b0};
              sda_low <= ~shift[6];
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end

        RD_ACK: begin
          if (scl_rise) begin
            master_ack <= ~sda_in;
          end else if (scl_fall) begin
            if (master_ack) begin
              pointer <= ptr_inc;
              shift   <= nxt_byte;
              sda_low <= ~nxt_byte[7];
              bit_cnt <= 4'd1;
              state   <= RD_DATA;
            end else begin
              sda_low <= 1'b0;
              state   <= WAIT_STOP;
            end
          end
        end

        default: begin
          sda_low <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave_top.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_slave_top
//  Description : Directed self-checking bench for i2c_slave_top. A bit-level
//                I2C master drives SCL and open-drain SDA; expected bytes and
//                ACK bits are hand-computed constants.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_slave_top;

  logic clk;
  logic rst;
  logic scl;
  logic m_sda_low;
  wire  sda_line;

  int n_checks;
  int n_fails;

  assign sda_line = m_sda_low ? 1'b0 : 1'bz;
  pullup (sda_line);

  i2c_slave_top #(
    .SLAVE_ADDR (7'h50),
    .MEM_DEPTH  (256)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .SCL_bus (scl),
    .SDA_bus (sda_line)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic qwait;
    repeat (10) @(negedge clk);
  endtask

  task automatic i2c_start;
    m_sda_low = 1'b0;
    qwait();
    scl = 1'b1;
    qwait();
    m_sda_low = 1'b1;
    qwait();
    scl = 1'b0;
    qwait();
  endtask

  task automatic i2c_stop;
    m_sda_low = 1'b1;
    qwait();
    scl = 1'b1;
    qwait();
    m_sda_low = 1'b0;
    qwait();
    qwait();
  endtask

  task automatic write_bit(input logic b);
    m_sda_low = ~b;
    qwait();
    scl = 1'b1;
    qwait();
    qwait();
    scl = 1'b0;
    qwait();
  endtask

  task automatic read_bit(output logic b);
    m_sda_low = 1'b0;
    qwait();
    scl = 1'b1;
    qwait();
    b = sda_line;
    qwait();
    scl = 1'b0;
    qwait();
  endtask

  // Send a byte and check the slave's ACK bit (0 = ACK, 1 = NACK)
  task automatic wr_chk(input string tag, input logic [7:0] d, input logic exp_ack);
    logic a;
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(a);
    check(tag, {15'd0, a}, {15'd0, exp_ack});
  endtask

  // Receive a byte, answer with ACK (nack=0) or NACK (nack=1), check data
  task automatic rd_chk(input string tag, input logic [7:0] exp, input logic nack);
    logic [7:0] d;
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(nack);
    check(tag, {8'd0, d}, {8'd0, exp});
  endtask

  // Pointer write followed by repeated START in read direction
  task automatic comb_setup(input logic [15:0] p);
    i2c_start();
    wr_chk("cs_dev_w", 8'hA0, 1'b0);
    wr_chk("cs_ptr_hi", p[15:8], 1'b0);
    wr_chk("cs_ptr_lo", p[7:0], 1'b0);
    i2c_start();
    wr_chk("cs_dev_r", 8'hA1, 1'b0);
  endtask

  initial begin
    logic b;
    n_checks  = 0;
    n_fails   = 0;
    rst       = 1'b0;
    scl       = 1'b1;
    m_sda_low = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    qwait();

    // Reset state: bus released, plain read at pointer 0 gives 0x00
    check("idle_sda", {15'd0, sda_line}, 16'd1);
    i2c_start();
    wr_chk("rst_dev_r", 8'hA1, 1'b0);
    rd_chk("rst_rd0", 8'h00, 1'b1);
    i2c_stop();

    // Burst write 01..04 at 0x0000
    i2c_start();
    wr_chk("bw_dev", 8'hA0, 1'b0);
    wr_chk("bw_hi", 8'h00, 1'b0);
    wr_chk("bw_lo", 8'h00, 1'b0);
    wr_chk("bw_d0", 8'h01, 1'b0);
    wr_chk("bw_d1", 8'h02, 1'b0);
    wr_chk("bw_d2", 8'h03, 1'b0);
    wr_chk("bw_d3", 8'h04, 1'b0);
    i2c_stop();

    // Combined read of 4 bytes
    comb_setup(16'h0000);
    rd_chk("cr_d0", 8'h01, 1'b0);
    rd_chk("cr_d1", 8'h02, 1'b0);
    rd_chk("cr_d2", 8'h03, 1'b0);
    rd_chk("cr_d3", 8'h04, 1'b1);
    check("cr_released", {15'd0, sda_line}, 16'd1);
    i2c_stop();

    // Wrong device address: NACK and everything ignored
    i2c_start();
    wr_chk("bad_addr", 8'hA2, 1'b1);
    wr_chk("bad_b0", 8'h00, 1'b1);
    wr_chk("bad_b1", 8'h00, 1'b1);
    wr_chk("bad_b2", 8'h55, 1'b1);
    i2c_stop();
    comb_setup(16'h0000);
    rd_chk("bad_mem0", 8'h01, 1'b1);
    i2c_stop();

    // Pointer wrap: 0x00FF -> AA, 0x0100 (index 0) -> BB, pointer ends at 0x0101
    i2c_start();
    wr_chk("wr_dev", 8'hA0, 1'b0);
    wr_chk("wr_hi", 8'h00, 1'b0);
    wr_chk("wr_lo", 8'hFF, 1'b0);
    wr_chk("wr_dAA", 8'hAA, 1'b0);
    wr_chk("wr_dBB", 8'hBB, 1'b0);
    i2c_stop();
    i2c_start();
    wr_chk("wr_plain_dev", 8'hA1, 1'b0);
    rd_chk("wr_plain_mem1", 8'h02, 1'b1);
    i2c_stop();
    comb_setup(16'h00FF);
    rd_chk("wr_memFF", 8'hAA, 1'b0);
    rd_chk("wr_mem00", 8'hBB, 1'b1);
    i2c_stop();

    // STOP in the middle of a data byte discards the partial byte
    i2c_start();
    wr_chk("ab_dev", 8'hA0, 1'b0);
    wr_chk("ab_hi", 8'h00, 1'b0);
    wr_chk("ab_lo", 8'h10, 1'b0);
    wr_chk("ab_d77", 8'h77, 1'b0);
    for (int i = 0; i < 4; i++) write_bit(1'b1);
    i2c_stop();
    comb_setup(16'h0010);
    rd_chk("ab_mem10", 8'h77, 1'b0);
    rd_chk("ab_mem11", 8'h00, 1'b1);
    i2c_stop();

    // Reset during a read of mem[0] = BB (1011_1011)
    comb_setup(16'h0000);
    read_bit(b);
    check("rr_bit7", {15'd0, b}, 16'd1);
    check("rr_bit6_drv", {15'd0, sda_line}, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rr_released", {15'd0, sda_line}, 16'd1);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    qwait();
    scl = 1'b1;
    qwait();
    i2c_start();
    wr_chk("rr_dev_r", 8'hA1, 1'b0);
    rd_chk("rr_mem0", 8'h00, 1'b1);
    i2c_stop();
    comb_setup(16'h00FF);
    rd_chk("rr_memFF", 8'h00, 1'b1);
    i2c_stop();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/i2c_slave_top.md
Name: i2c_slave_top

Overview:
I2C slave that exposes a byte-addressable register memory over a two-wire bus, sitting at the chip boundary between the SCL/SDA pads and internal storage. It runs on a fast system clock (27 MHz nominal) and oversamples the bus (standard/fast mode up to 400 kHz). It uses a 7-bit device address, a 16-bit register pointer sent MSB byte first, multi-byte burst writes and reads, and pointer auto-increment.

Parameters:
SLAVE_ADDR, 7'h50, 7-bit device address the block responds to.
MEM_DEPTH, 256, number of byte locations (power of two); memory index = pointer mod MEM_DEPTH.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous, active-low reset.
SCL_bus  input  1  I2C clock from master; no clock stretching.
SDA_bus  inout  1  I2C data, open-drain: block drives 0 or high-Z only, never 1; external pull-up.

Behaviour:
- Input conditioning: SCL and SDA each pass through a 2-FF synchronizer, plus one more register for edge detection. Rising/falling SCL and SDA edges are single-clk pulses.
- START: SDA falls while SCL high. STOP: SDA rises while SCL high. Both are valid in any state. START (including repeated START) -> DEV_ADDR with bit counter cleared. STOP -> IDLE with SDA released.
- Timing rules: data bits are sampled on SCL rising edges. The SDA driver is updated only on SCL falling edges, so SDA is stable while SCL is high.
- States: IDLE, DEV_ADDR, ACK_DEV, REG_HI, ACK_HI, REG_LO, ACK_LO, WR_DATA, ACK_WR, RD_DATA, RD_ACK, WAIT_STOP.
- DEV_ADDR: shift in 8 bits, MSB first (7 address bits + R/W). On the 8th-bit falling edge:
  - address == SLAVE_ADDR: drive SDA low (ACK) -> ACK_DEV.
  - mismatch: leave SDA released (NACK) -> WAIT_STOP, ignore the bus until the next START/STOP.
- ACK_DEV: release SDA on the next falling edge.
  - R/W=0 -> REG_HI.
  - R/W=1 -> RD_DATA, and on that same falling edge present bit 7 of mem[pointer].
- REG_HI / REG_LO: receive pointer[15:8], then pointer[7:0], each followed by a slave ACK (ACK_HI / ACK_LO), same ACK timing as ACK_DEV. After ACK_LO -> WR_DATA.
- WR_DATA: receive 8 bits. On the 8th bit, write mem[pointer] and increment pointer (16-bit, 0xFFFF wraps to 0x0000). ACK every data byte (ACK_WR), then return to WR_DATA. A STOP or START here ends the write; a partially received byte is discarded.
- RD_DATA: shift out mem[pointer] MSB first, one bit per SCL falling edge. After the 8th bit, release SDA -> RD_ACK.
- RD_ACK: sample master ACK on the 9th SCL rising edge.
  - ACK (0): increment pointer, load next byte and drive its MSB on the following falling edge -> RD_DATA.
  - NACK (1): keep SDA released -> WAIT_STOP.
- Combined read: a write of the 2 pointer bytes, then repeated START with R/W=1, reads from the new pointer. A read after a plain START uses the current pointer.
- The pointer persists across transactions until rewritten. There is no general-call support.
- Reset (also mid-transaction): state IDLE, SDA released (high-Z), pointer 0x0000, all memory bytes 0x00, shift registers and bit counter cleared.

Test Plan:
- After reset: SDA stays high-Z on idle bus; a read at 0x0000 returns 0x00.
- Burst write: START, 0xA0, 0x00, 0x00, 0x01 0x02 0x03 0x04, STOP -> 7 slave ACKs; mem[0..3] = 01,02,03,04.
- Combined read: START, 0xA0, 0x00, 0x00, rSTART, 0xA1, read 4 bytes (master ACK x3, NACK last), STOP -> returns 01 02 03 04, SDA released after NACK.
- Wrong address: START, 0xA2 -> 9th bit SDA high (NACK); following bytes ignored; memory unchanged.
- Pointer wrap: write pointer 0x00FF, then data AA, BB -> mem[0xFF]=AA, mem[0x00]=BB (MEM_DEPTH=256); a following plain read returns mem[0x01].
- Abort/reset: STOP mid-byte during a write leaves memory untouched; asserting rst low mid-read releases SDA within 1 clk and restores reset values.
